afe_frame_buffer: RTL

- Parametrised, double-buffered (ping-pong) capture buffer for AFE result registers.
- The SPI readout side writes one frame of NUM_CH channel words: LED2, ALED2, LED2-ALED2, LED1, ALED1, LED1-ALED1, DIAG.
- When every channel of the frame has been written, the banks swap atomically and the completed frame is presented to the data-buffer side.
- The read side is a request/response port, with MSB stripping and frame-level flow control (release, overflow).

---
 rtl/pulseox_pkg.sv | 18 +
 rtl/sdp_ram.sv | 21 ++
 rtl/afe_frame_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/pulseox_pkg.sv
// Shared defaults and channel map for the pulse-oximeter AFE capture path.
package pulseox_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_OUT_W  = 22;
  localparam int DEF_NUM_CH = 7;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_CNT_W  = 16;

  localparam int CH_LED2       = 0;
  localparam int CH_ALED2      = 1;
  localparam int CH_LED2_ALED2 = 2;
  localparam int CH_LED1       = 3;
  localparam int CH_ALED1      = 4;
  localparam int CH_LED1_ALED1 = 5;
  localparam int CH_DIAG       = 6;

  typedef enum logic {RD_EMPTY = 1'b0, RD_FULL = 1'b1} rd_state_e;
endpackage

// File: rtl/sdp_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
module sdp_ram #(
  parameter int DW    = 24,
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/afe_frame_buffer.sv
// Ping-pong frame buffer: SPI readout fills one bank while the consumer reads the other.
module afe_frame_buffer
  import pulseox_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              frame_rdy,
  input  logic              frame_release,
  input  logic              overflow_clr,
  output logic              overflow,
  output logic              wr_err,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] NCH = AW1'(NUM_CH);

  rd_state_e           state, state_n;
  logic                wr_bank;
  logic [NUM_CH-1:0]   mask, wr_bit;
  logic                wr_in, rd_in, we, rd_acc, rd_zero;
  logic                mask_full, commit, drop, wbank_eff;
  logic [AW1-1:0]      ram_wa, ram_ra;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-OUT_W-1:0] rd_msb_unused;

  assign wr_in     = {1'b0, wr_addr} < NCH;
  assign rd_in     = {1'b0, rd_addr} < NCH;
  assign we        = wr_en & wr_in;
  assign wr_bit    = we ? (NUM_CH'(1) << wr_addr) : '0;
  assign mask_full = &mask;
  // The completing write lands one edge before the commit decision is taken.
  assign commit    = mask_full & (~frame_rdy | frame_release);
  assign drop      = mask_full & frame_rdy & ~frame_release;
  // A write on the commit edge already belongs to the freshly swapped bank.
  assign wbank_eff = commit ? ~wr_bank : wr_bank;
  assign ram_wa    = wbank_eff ? ({1'b0, wr_addr} + NCH) : {1'b0, wr_addr};
  assign ram_ra    = ~wr_bank  ? ({1'b0, rd_addr} + NCH) : {1'b0, rd_addr};
  assign rd_acc    = rd_req & frame_rdy;

  sdp_ram #(.DW(DATA_W), .DEPTH(2*NUM_CH), .AW(AW1)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ram_wa),
    .wdata (wr_data),
    .re    (rd_acc & rd_in),
    .raddr (ram_ra),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RD_EMPTY;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (commit)                                state_n = RD_FULL;
    else if (state == RD_FULL && frame_release) state_n = RD_EMPTY;
  end

  always_comb begin
    frame_rdy = (state == RD_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_bank   <= 1'b0;
      mask      <= '0;
      overflow  <= 1'b0;
      wr_err    <= 1'b0;
      frame_cnt <= '0;
      rd_valid  <= 1'b0;
      rd_zero   <= 1'b1;
    end else begin
      wr_err   <= wr_en & ~wr_in;
      mask     <= (mask_full ? '0 : mask) | wr_bit;
      rd_valid <= rd_acc;
      if (rd_acc) rd_zero <= ~rd_in;
      if (commit) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // The AFE never drives the top bits, so only the low OUT_W bits reach the port.
  assign rd_data       = rd_zero ? '0 : ram_q[OUT_W-1:0];
  assign rd_msb_unused = ram_q[DATA_W-1:OUT_W];
endmodule
